// File: rtl/kronos_spsram_arb.sv
// kronos_spsram_arb: single-port SRAM arbiter between an instruction fetch
// port and a load/store port. Data has priority over instruction; with
// KRONOS_ARB_STARVE_GUARD_EN defined, a saturating starvation counter forces
// an instruction grant after STARVE_MAX consecutive instruction denials.
// Grants are registered and line up with the SRAM's 1-cycle read latency.
module kronos_spsram_arb #(
  parameter int MEMSIZE    = 11,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rstz,
  input  logic [31:0]        instr_addr,
  input  logic               instr_req,
  output logic [31:0]        instr_data,
  output logic               instr_gnt,
  input  logic [31:0]        data_addr,
  input  logic [31:0]        data_wr_data,
  input  logic [3:0]         data_wr_mask,
  input  logic               data_rd_req,
  input  logic               data_wr_req,
  output logic [31:0]        data_rd_data,
  output logic               data_gnt,
  output logic [MEMSIZE-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  output logic               mem_en,
  output logic               mem_wren,
  output logic [3:0]         mem_wmask,
  output logic               starve_evt
);

  typedef enum logic [1:0] {OWN_NONE, OWN_DATA, OWN_INSTR} owner_e;

  owner_e owner;
  logic   data_req;
  logic   force_instr;
  logic   instr_gnt_q, instr_gnt_d;
  logic   data_gnt_q, data_gnt_d;

  assign data_req = data_rd_req | data_wr_req;

`ifdef KRONOS_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign force_instr = instr_req && (starve_cnt_q == 4'(STARVE_MAX));

  // Count consecutive cycles the instruction port lost to data; saturate at the limit.
  always_comb begin
    starve_cnt_d = 4'd0;
    if (instr_req && owner == OWN_DATA)
      starve_cnt_d = (starve_cnt_q == 4'(STARVE_MAX)) ? starve_cnt_q : starve_cnt_q + 4'd1;
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) starve_cnt_q <= 4'd0;
    else       starve_cnt_q <= starve_cnt_d;
  end

  // Pulses only in the cycle the forced grant is issued, since the counter clears then.
  assign starve_evt = rstz & force_instr;
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = (STARVE_MAX != 0);
  assign force_instr       = 1'b0;
  assign starve_evt        = 1'b0;
`endif

  // Pick this cycle's owner from live requests: forced instr, then data, then instr.
  always_comb begin
    owner = OWN_NONE;
    if (force_instr)    owner = OWN_INSTR;
    else if (data_req)  owner = OWN_DATA;
    else if (instr_req) owner = OWN_INSTR;
  end

  // Enables are gated by reset so the SRAM sees no access while rstz is low.
  assign mem_en    = rstz && (owner != OWN_NONE);
  assign mem_wren  = rstz && (owner == OWN_DATA) && data_wr_req;
  assign mem_addr  = (owner == OWN_INSTR) ? instr_addr[2 +: MEMSIZE] : data_addr[2 +: MEMSIZE];
  assign mem_wdata = data_wr_data;
  assign mem_wmask = data_wr_mask;

  assign instr_data   = mem_rdata;
  assign data_rd_data = mem_rdata;

  // Address bits outside the word index are intentionally dropped (wrap).
  logic unused_addr;
  assign unused_addr = ^{instr_addr[31:MEMSIZE+2], instr_addr[1:0],
                         data_addr[31:MEMSIZE+2], data_addr[1:0]};

  // Next-cycle grants mirror this cycle's owner.
  always_comb begin
    instr_gnt_d = (owner == OWN_INSTR);
    data_gnt_d  = (owner == OWN_DATA);
  end

  // Grant registers; reset drops any grant in flight.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      instr_gnt_q <= 1'b0;
      data_gnt_q  <= 1'b0;
    end else begin
      instr_gnt_q <= instr_gnt_d;
      data_gnt_q  <= data_gnt_d;
    end
  end

  assign instr_gnt = instr_gnt_q;
  assign data_gnt  = data_gnt_q;

endmodule

// File: doc/kronos_spsram_arb.md
KRONOS_SPSRAM_ARB -- requirements
Module: kronos_spsram_arb

Interface
REQ-001 SHALL have parameter MEMSIZE, default 11, log2 of SRAM depth in 32-bit words (legal 4..20).
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive instruction denials before a forced instruction grant (legal 1..15).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have ports:
- clk  input  1  clock
- rstz  input  1  async active-low reset
- instr_addr  input  32  instruction byte address
- instr_req  input  1  instruction read request
- instr_data  output  32  instruction read data
- instr_gnt  output  1  instruction grant, data valid
- data_addr  input  32  data byte address
- data_wr_data  input  32  store data
- data_wr_mask  input  4  byte write enables
- data_rd_req  input  1  load request
- data_wr_req  input  1  store request
- data_rd_data  output  32  load data
- data_gnt  output  1  data grant
- mem_addr  output  MEMSIZE  SRAM word address
- mem_wdata  output  32  SRAM write data
- mem_rdata  input  32  SRAM read data, 1-cycle latency
- mem_en  output  1  SRAM enable
- mem_wren  output  1  SRAM write enable
- mem_wmask  output  4  SRAM byte mask
- starve_evt  output  1  pulse, forced instruction grant taken

Function
REQ-005 SHALL select one owner per cycle, combinationally from current requests: DATA, INSTR or NONE.
REQ-006 Default priority SHALL be data over instruction.
REQ-007 mem_en SHALL equal (owner != NONE); mem_addr SHALL be the owner's address bits [2+:MEMSIZE]; address bits above MEMSIZE+1 SHALL be ignored (wrap).
REQ-008 mem_wren SHALL be high only when owner==DATA and data_wr_req=1; data_rd_req and data_wr_req both high SHALL be treated as a write.
REQ-009 mem_wdata and mem_wmask SHALL pass data_wr_data and data_wr_mask through unconditionally.
REQ-010 instr_data and data_rd_data SHALL both pass mem_rdata through unconditionally.
REQ-011 instr_gnt and data_gnt SHALL be registered: high in cycle N+1 iff owner was INSTR/DATA in cycle N; never both high.
REQ-012 Requesters SHALL hold request and address stable until grant; arbiter SHALL re-arbitrate every cycle and SHALL accept back-to-back requests (one grant per cycle, 100% throughput).
REQ-013 Starvation counter (4 bits) SHALL increment, saturating at STARVE_MAX, each cycle instr_req=1 and owner==DATA; SHALL clear when owner==INSTR or instr_req=0.
REQ-014 When counter==STARVE_MAX and instr_req=1, owner SHALL be INSTR regardless of data requests; starve_evt SHALL be high that cycle only; the data request SHALL win the following cycle.

Reset
REQ-015 While rstz=0: instr_gnt=0, data_gnt=0, counter=0, starve_evt=0, mem_en=0, mem_wren=0, asynchronously.
REQ-016 Reset asserted mid-transaction SHALL drop any pending grant; first arbitration SHALL occur on the first clk edge after rstz rises.

Configuration
REQ-017 Macro KRONOS_ARB_STARVE_GUARD_EN SHALL compile in REQ-013/REQ-014; without it, priority SHALL be strict data-over-instruction, no counter SHALL exist, and starve_evt SHALL be tied 0.

Verification
REQ-018 Instr-only: instr_req=1, instr_addr=0x10, MEM[4]=0xDEADBEEF -> next cycle instr_gnt=1, instr_data=0xDEADBEEF, data_gnt=0.
REQ-019 Store: data_wr_req=1, data_addr=0x20, data_wr_data=0x12345678, mask=0x3 -> mem_wren=1, mem_addr=8, next cycle data_gnt=1, MEM[8] low halfword=0x5678, upper bytes unchanged.
REQ-020 Collision, guard off: instr_req and data_rd_req both held 10 cycles -> data_gnt every cycle 2..11, instr_gnt never.
REQ-021 Collision, guard on, STARVE_MAX=4: instr_req and data_rd_req held -> data_gnt 4 cycles, instr_gnt 1 cycle with starve_evt pulsed one cycle earlier, then data_gnt again; pattern repeats.
REQ-022 Wrap: MEMSIZE=11, data_addr=0x2004 read -> mem_addr=1.
REQ-023 Reset mid-op: rstz driven low during a granted data read -> data_gnt and mem_en low immediately, counter reads 0 after release.
